// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding,
// byte-to-word shift and starvation counter width.
package dmem_pkg;

   // Registered last owner of the memory port
   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   // Byte address to word index: drop the two byte-lane bits
   localparam int WORD_SHIFT = 2;

   // Wide enough for a starvation limit of up to 15
   localparam int STARVE_W = 4;

   // Requester slots for the per-port address checkers
   localparam int NUM_PORTS = 2;
   localparam int PORT_CPU  = 0;
   localparam int PORT_DMA  = 1;

endpackage

// File: rtl/dmem_addr_check.sv
// Byte address to word index conversion with range check.
// Optional macro DMEM_ALIGN_CHECK_EN: a non-word-aligned address is also
// reported as out of range. Without it the byte-lane bits are ignored.
module dmem_addr_check
   import dmem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 64,
   parameter int IDX_W     = 6
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic              in_range
);

   logic [ADDR_W-1:0] word_addr;
   logic              word_ok;
   logic              align_ok;

   // Full word address so that any set upper bit flags out of range,
   // not just the bits that fit in the index
   assign word_addr = addr >> WORD_SHIFT;
   assign word_ok   = (word_addr < ADDR_W'(MEM_WORDS));
   assign idx       = addr[IDX_W+WORD_SHIFT-1:WORD_SHIFT];

`ifdef DMEM_ALIGN_CHECK_EN
   assign align_ok  = (addr[WORD_SHIFT-1:0] == '0);
`else
   assign align_ok  = 1'b1;
`endif

   assign in_range  = word_ok && align_ok;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the pipeline MEM stage (CPU)
// and a DMA/loader port. CPU has fixed priority; a starvation counter
// forces a DMA grant after STARVE_MAX consecutive denied cycles.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned accesses are treated as
// out of range (see dmem_addr_check).
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int MEM_WORDS  = 64,
   parameter int IDX_W      = 6,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic [IDX_W-1:0]  mem_idx,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic              err_oob,
   input  logic              err_clr
);

   owner_t                owner_reg, owner_next;
   logic [STARVE_W-1:0]   starve_cnt_reg, starve_cnt_next;
   logic                  err_oob_reg, err_oob_next;
   logic                  err_set;
   logic                  force_dma;

   logic [ADDR_W-1:0]     port_addr [NUM_PORTS];
   logic [IDX_W-1:0]      port_idx  [NUM_PORTS];
   logic [NUM_PORTS-1:0]  port_ok;

   assign port_addr[PORT_CPU] = cpu_addr;
   assign port_addr[PORT_DMA] = dma_addr;

   // One address checker per requester so the grant mux only selects results
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_addr_check
         dmem_addr_check #(
            .ADDR_W    (ADDR_W),
            .MEM_WORDS (MEM_WORDS),
            .IDX_W     (IDX_W)
         ) u_addr_check (
            .addr     (port_addr[gi]),
            .idx      (port_idx[gi]),
            .in_range (port_ok[gi])
         );
      end
   endgenerate

   // DMA has waited its limit: it wins this cycle regardless of the CPU
   assign force_dma = dma_req && (starve_cnt_reg == STARVE_W'(STARVE_MAX));

   // Grant decision, memory mux and next state; everything stays quiet in reset
   always_comb begin
      cpu_stall       = 1'b0;
      dma_ack         = 1'b0;
      mem_we          = 1'b0;
      mem_idx         = '0;
      mem_wdata       = '0;
      cpu_rdata       = '0;
      dma_rdata       = '0;
      err_set         = 1'b0;
      owner_next      = OWN_IDLE;
      starve_cnt_next = '0;

      if (resetn) begin
         if (cpu_req && !force_dma) begin
            owner_next = OWN_CPU;
            mem_idx    = port_idx[PORT_CPU];
            mem_wdata  = cpu_wdata;
            mem_we     = cpu_we && port_ok[PORT_CPU];
            cpu_rdata  = port_ok[PORT_CPU] ? mem_rdata : '0;
            err_set    = !port_ok[PORT_CPU];
            // A denied pending DMA ages; a dropped request resets the count
            if (dma_req) begin
               if (starve_cnt_reg < STARVE_W'(STARVE_MAX))
                  starve_cnt_next = starve_cnt_reg + 1'b1;
               else
                  starve_cnt_next = starve_cnt_reg;
            end
         end else if (dma_req) begin
            owner_next = OWN_DMA;
            dma_ack    = 1'b1;
            cpu_stall  = cpu_req;
            mem_idx    = port_idx[PORT_DMA];
            mem_wdata  = dma_wdata;
            mem_we     = dma_we && port_ok[PORT_DMA];
            dma_rdata  = port_ok[PORT_DMA] ? mem_rdata : '0;
            err_set    = !port_ok[PORT_DMA];
         end
      end

      // Sticky error: a new fault in the same cycle beats the clear
      if (err_set)
         err_oob_next = 1'b1;
      else if (err_clr)
         err_oob_next = 1'b0;
      else
         err_oob_next = err_oob_reg;
   end

   // Owner, starvation count and sticky error registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_reg      <= OWN_IDLE;
         starve_cnt_reg <= '0;
         err_oob_reg    <= 1'b0;
      end else begin
         owner_reg      <= owner_next;
         starve_cnt_reg <= starve_cnt_next;
         err_oob_reg    <= err_oob_next;
      end
   end

   assign owner   = owner_reg;
   assign err_oob = err_oob_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural
// negedge-write memory, plus hand-written reset-during-contention sequence.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_req, cpu_we, dma_req, dma_we, err_clr;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
   logic        cpu_stall, dma_ack, mem_we, err_oob;
   logic [5:0]  mem_idx;
   logic [1:0]  owner;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk       (clk),
      .resetn    (resetn),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ack   (dma_ack),
      .mem_idx   (mem_idx),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .owner     (owner),
      .err_oob   (err_oob),
      .err_clr   (err_clr)
   );

   // Memory: combinational read, write on the falling edge
   logic [31:0] mem_model [0:63] = '{default: 32'h0};
   assign mem_rdata = mem_model[mem_idx];
   always @(negedge clk) if (mem_we) mem_model[mem_idx] <= mem_wdata;

   typedef struct {
      logic        creq, cwe;
      logic [31:0] ca, cwd;
      logic        dreq, dwe;
      logic [31:0] da, dwd;
      logic        clr;
      logic        es, ea, ew;
      logic [5:0]  ei;
      logic [31:0] ecr, edr;
      logic [1:0]  eo;
      logic        ee;
   } vec_t;

   vec_t vt [0:63];
   int   nv = 0;

   task automatic add(input logic creq, cwe, input logic [31:0] ca, cwd,
                      input logic dreq, dwe, input logic [31:0] da, dwd,
                      input logic clr, input logic es, ea, ew, input logic [5:0] ei,
                      input logic [31:0] ecr, edr, input logic [1:0] eo, input logic ee);
      vt[nv].creq = creq; vt[nv].cwe = cwe; vt[nv].ca = ca; vt[nv].cwd = cwd;
      vt[nv].dreq = dreq; vt[nv].dwe = dwe; vt[nv].da = da; vt[nv].dwd = dwd;
      vt[nv].clr = clr;   vt[nv].es = es;   vt[nv].ea = ea; vt[nv].ew = ew;
      vt[nv].ei = ei;     vt[nv].ecr = ecr; vt[nv].edr = edr;
      vt[nv].eo = eo;     vt[nv].ee = ee;
      nv++;
   endtask

   task automatic idle(input logic clr, input logic [1:0] eo, input logic ee);
      add(0,0,0,0, 0,0,0,0, clr, 0,0,0,6'd0, 0,0, eo, ee);
   endtask

   task automatic chk(input string nm, input int vi, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %h required %h", nm, vi, act, exp);
      end
   endtask

   task automatic set_in(input logic creq, cwe, input logic [31:0] ca, cwd,
                         input logic dreq, dwe, input logic [31:0] da, dwd, input logic clr);
      cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
      dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
      err_clr = clr;
   endtask

   localparam logic [1:0] I = 2'd0, C = 2'd1, D = 2'd2;

   initial begin
      // ---------------- vector table ----------------
      // CPU only: write then read word 4
      add(1,1,32'h10,32'h12345678, 0,0,0,0, 0, 0,0,1,6'd4, 32'h0,32'h0, I,0);
      add(1,0,32'h10,32'h0,        0,0,0,0, 0, 0,0,0,6'd4, 32'h12345678,32'h0, C,0);
      idle(0, C, 0);
      // DMA only: load word 9, then read it back
      add(0,0,0,0, 1,1,32'h24,32'h90000099, 0, 0,1,1,6'd9, 32'h0,32'h0, I,0);
      add(0,0,0,0, 1,0,32'h24,32'h0,        0, 0,1,0,6'd9, 32'h0,32'h90000099, D,0);
      idle(0, D, 0);
      // Contention: 4 CPU grants, forced DMA on the 5th, twice
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            add(1,0,32'h10,0, 1,0,32'h24,0, 0, 0,0,0,6'd4, 32'h12345678,32'h0,
                (k == 0) ? ((r == 0) ? I : D) : C, 0);
         add(1,0,32'h10,0, 1,0,32'h24,0, 0, 1,1,0,6'd9, 32'h0,32'h90000099, C,0);
      end
      idle(0, D, 0);
      // Dropping dma_req clears the starvation count
      add(1,0,32'h10,0, 1,0,32'h24,0, 0, 0,0,0,6'd4, 32'h12345678,32'h0, I,0);
      add(1,0,32'h10,0, 1,0,32'h24,0, 0, 0,0,0,6'd4, 32'h12345678,32'h0, C,0);
      add(1,0,32'h10,0, 0,0,0,0,        0, 0,0,0,6'd4, 32'h12345678,32'h0, C,0);
      for (int k = 0; k < 4; k++)
         add(1,0,32'h10,0, 1,0,32'h24,0, 0, 0,0,0,6'd4, 32'h12345678,32'h0, C,0);
      add(1,0,32'h10,0, 1,0,32'h24,0, 0, 1,1,0,6'd9, 32'h0,32'h90000099, C,0);
      idle(0, D, 0);
      // CPU out of range (word 64): no write, sticky error, then clear
      add(1,1,32'h100,32'hDEADBEEF, 0,0,0,0, 0, 0,0,0,6'd0, 32'h0,32'h0, I,0);
      idle(0, C, 1);
      idle(0, I, 1);
      idle(1, I, 1);
      idle(0, I, 0);
      // DMA out of range with err_clr in the same cycle: set wins
      add(0,0,0,0, 1,0,32'h200,0, 1, 0,1,0,6'd0, 32'h0,32'h0, I,0);
      idle(0, D, 1);
      idle(1, I, 1);
      idle(0, I, 0);
      // Top in-range word 63 by CPU, then DMA write/read word 16
      add(1,1,32'hFC,32'hA5A50F0F, 0,0,0,0, 0, 0,0,1,6'd63, 32'h0,32'h0, I,0);
      add(1,0,32'hFC,0,            0,0,0,0, 0, 0,0,0,6'd63, 32'hA5A50F0F,32'h0, C,0);
      add(0,0,0,0, 1,1,32'h40,32'h11112222, 0, 0,1,1,6'd16, 32'h0,32'h0, C,0);
      add(0,0,0,0, 1,0,32'h40,0,            0, 0,1,0,6'd16, 32'h0,32'h11112222, D,0);
      // Misaligned CPU write at 0x11
`ifdef DMEM_ALIGN_CHECK_EN
      add(1,1,32'h11,32'hCAFEF00D, 0,0,0,0, 0, 0,0,0,6'd4, 32'h0,32'h0, D,0);
      add(1,0,32'h10,0,            0,0,0,0, 0, 0,0,0,6'd4, 32'h12345678,32'h0, C,1);
      idle(1, C, 1);
`else
      add(1,1,32'h11,32'hCAFEF00D, 0,0,0,0, 0, 0,0,1,6'd4, 32'h12345678,32'h0, D,0);
      add(1,0,32'h10,0,            0,0,0,0, 0, 0,0,0,6'd4, 32'hCAFEF00D,32'h0, C,0);
      idle(1, C, 0);
`endif
      idle(0, I, 0);
      // High address bit set: idx wraps to 4 but access is out of range
      add(1,0,32'h80000010,0, 0,0,0,0, 0, 0,0,0,6'd4, 32'h0,32'h0, I,0);
      idle(0, C, 1);
      idle(1, I, 1);
      idle(0, I, 0);

      // ---------------- reset state ----------------
      resetn = 1'b0;
      set_in(1,1,32'h10,32'hFFFFFFFF, 1,1,32'h24,32'hFFFFFFFF, 0);
      #3;
      chk("rst cpu_stall", -1, 32'(cpu_stall), 32'h0);
      chk("rst dma_ack",   -1, 32'(dma_ack),   32'h0);
      chk("rst mem_we",    -1, 32'(mem_we),    32'h0);
      chk("rst mem_idx",   -1, 32'(mem_idx),   32'h0);
      chk("rst cpu_rdata", -1, cpu_rdata,      32'h0);
      chk("rst dma_rdata", -1, dma_rdata,      32'h0);
      @(posedge clk); #1;
      chk("rst owner",     -1, 32'(owner),     32'h0);
      chk("rst err_oob",   -1, 32'(err_oob),   32'h0);
      set_in(0,0,0,0, 0,0,0,0, 0);
      resetn = 1'b1;

      // ---------------- apply table ----------------
      for (int i = 0; i < nv; i++) begin
         @(posedge clk); #1;
         set_in(vt[i].creq, vt[i].cwe, vt[i].ca, vt[i].cwd,
                vt[i].dreq, vt[i].dwe, vt[i].da, vt[i].dwd, vt[i].clr);
         #2;
         $display("vec %0d: creq=%0b dreq=%0b stall=%0b ack=%0b we=%0b idx=%0d crd=%h drd=%h own=%0d err=%0b",
                  i, cpu_req, dma_req, cpu_stall, dma_ack, mem_we, mem_idx, cpu_rdata, dma_rdata, owner, err_oob);
         chk("cpu_stall", i, 32'(cpu_stall), 32'(vt[i].es));
         chk("dma_ack",   i, 32'(dma_ack),   32'(vt[i].ea));
         chk("mem_we",    i, 32'(mem_we),    32'(vt[i].ew));
         chk("mem_idx",   i, 32'(mem_idx),   32'(vt[i].ei));
         chk("cpu_rdata", i, cpu_rdata,      vt[i].ecr);
         chk("dma_rdata", i, dma_rdata,      vt[i].edr);
         chk("owner",     i, 32'(owner),     32'(vt[i].eo));
         chk("err_oob",   i, 32'(err_oob),   32'(vt[i].ee));
      end

      // ---------------- reset during contention ----------------
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         set_in(1,0,32'h10,0, 1,1,32'h44,32'h5555AAAA, 0);
         #2;
         $display("pre-rst cycle %0d: stall=%0b ack=%0b we=%0b", k, cpu_stall, dma_ack, mem_we);
         chk("pre cpu_stall", k, 32'(cpu_stall), 32'(k == 4));
         chk("pre dma_ack",   k, 32'(dma_ack),   32'(k == 4));
         chk("pre mem_we",    k, 32'(mem_we),    32'(k == 4));
      end
      #1 resetn = 1'b0;
      #1;
      $display("in-rst: stall=%0b ack=%0b we=%0b idx=%0d own=%0d", cpu_stall, dma_ack, mem_we, mem_idx, owner);
      chk("mid cpu_stall", 0, 32'(cpu_stall), 32'h0);
      chk("mid dma_ack",   0, 32'(dma_ack),   32'h0);
      chk("mid mem_we",    0, 32'(mem_we),    32'h0);
      chk("mid mem_idx",   0, 32'(mem_idx),   32'h0);
      chk("mid owner",     0, 32'(owner),     32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      #2;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            @(posedge clk); #3;
         end
         $display("post-rst cycle %0d: stall=%0b ack=%0b own=%0d", k, cpu_stall, dma_ack, owner);
         chk("post cpu_stall", k, 32'(cpu_stall), 32'(k == 4));
         chk("post dma_ack",   k, 32'(dma_ack),   32'(k == 4));
      end
      chk("post owner", 4, 32'(owner), 32'(C));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-ported data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. It converts byte addresses to word indices and drives the memory's address, write data and write enable. It asserts a stall to the pipeline when DMA takes a cycle. CPU has fixed priority; a starvation counter guarantees DMA forward progress.

Parameters:
DATA_W, 32, data width of both ports and the memory
ADDR_W, 32, byte-address width of both ports
MEM_WORDS, 64, memory depth in words
IDX_W, 6, word-index width, clog2(MEM_WORDS)
STARVE_MAX, 4, consecutive cycles DMA may be denied while pending before a forced DMA grant (1..15)

Ports:
clk  in  1  system clock; posedge logic, memory writes on negedge
resetn  in  1  asynchronous active-low reset
cpu_req  in  1  MEM-stage access request
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data
cpu_stall  out  1  CPU request not served this cycle; freeze pipeline
dma_req  in  1  DMA access request, held until acked
dma_we  in  1  DMA write / read
dma_addr  in  ADDR_W  DMA byte address
dma_wdata  in  DATA_W  DMA write data
dma_rdata  out  DATA_W  DMA read data, valid while dma_ack=1
dma_ack  out  1  DMA access performed this cycle
mem_idx  out  IDX_W  word index to memory
mem_wdata  out  DATA_W  write data to memory
mem_we  out  1  memory write enable, sampled at negedge clk
mem_rdata  in  DATA_W  combinational read data from memory
owner  out  2  registered last owner: 0 IDLE, 1 CPU, 2 DMA
err_oob  out  1  sticky: an out-of-range access occurred
err_clr  in  1  synchronous clear of err_oob

Behaviour:
- Reset (resetn=0, async): owner=IDLE, starve_cnt=0, err_oob=0. While resetn=0, cpu_stall=0, dma_ack=0, mem_we=0, mem_idx=0, cpu_rdata=0, dma_rdata=0.
- Grant decision is combinational each cycle from requests and registered starve_cnt. Zero-latency access; read data returns in the same cycle.
  - force = dma_req && starve_cnt==STARVE_MAX.
  - cpu_req && !force: grant CPU. If dma_req, starve_cnt<=starve_cnt+1 (saturating).
  - else if dma_req: grant DMA, dma_ack=1, starve_cnt<=0, cpu_stall=cpu_req.
  - else: no grant, starve_cnt<=0, mem_we=0.
  - dma_req=0 in any cycle clears starve_cnt.
- FSM owner (posedge): IDLE->CPU on CPU grant, ->DMA on DMA grant, ->IDLE with no request. All transitions are possible from any state.
- Address: idx = addr[IDX_W+1:2]. The access is out of range if addr>>2 >= MEM_WORDS.
  - On out-of-range: mem_we suppressed, the granted port's rdata=0, err_oob<=1.
  - err_oob is sticky. err_clr clears it; a set in the same cycle wins over err_clr.
- mem_we = granted write && in-range. mem_wdata and mem_idx come from the granted port; both are 0 when no grant.
- Ungranted port rdata=0. cpu_rdata is valid only when cpu_req && !cpu_stall.
- Reset mid-stall: stall and ack drop immediately; starve_cnt is lost.
- A requester changing its request while stalled is legal: the decision uses current inputs only.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- With the macro defined: a granted access with addr[1:0]!=0 is treated as out-of-range (no write, rdata=0, sets err_oob).
- Without the macro: addr[1:0] is ignored and the access proceeds on the truncated word index.

Decomposition:
- Package dmem_pkg: owner encoding (OWN_IDLE=0, OWN_CPU=1, OWN_DMA=2) and the byte-to-word shift constant WORD_SHIFT=2.
- One sub-module, dmem_addr_check: byte address to idx plus in_range flag; alignment check under the macro. Instantiated once per port.

Test Plan:
- CPU only: write 0x12345678 at addr 0x10, then read addr 0x10 -> mem_idx=4, mem_we=1 then 0, cpu_rdata=0x12345678, cpu_stall=0 throughout.
- DMA only: read addr 0x24 with memory word 9 = 0x90000099 -> dma_ack=1 that cycle, dma_rdata=0x90000099, owner=DMA next cycle.
- Contention, STARVE_MAX=4: cpu_req and dma_req held continuously -> CPU granted 4 cycles, cycle 5 dma_ack=1 and cpu_stall=1, then CPU again. Pattern repeats every 5 cycles.
- Out of range: CPU write at addr 0x100 (word 64) -> mem_we=0, err_oob=1 next cycle and stays. Pulse err_clr -> err_oob=0.
- Misaligned: CPU write at 0x11 -> with DMEM_ALIGN_CHECK_EN, mem_we=0 and err_oob=1. Without the macro, mem_idx=4 and mem_we=1.
- Reset during contention: deassert resetn while cpu_stall=1 -> cpu_stall, dma_ack and mem_we go 0 immediately, owner=IDLE. After release, starve count restarts from 0 (4 CPU cycles before the next forced DMA).
